// File: rtl/mips_pipe_pkg.sv
// Shared types for the MIPS inter-stage pipeline registers: occupancy state
// and the per-stage payload layouts that callers pack into PAYLOAD_W bits.
package mips_pipe_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned REG_W = 5;
  localparam int unsigned ALU_W = 4;

  typedef enum logic [1:0] {
    PS_EMPTY = 2'd0,
    PS_ONE   = 2'd1,
    PS_TWO   = 2'd2
  } pipe_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } if_id_t;

  typedef struct packed {
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  rs_val;
    logic [XLEN-1:0]  rt_val;
    logic [XLEN-1:0]  imm;
    logic [REG_W-1:0] rd;
    logic [ALU_W-1:0] alu_op;
    logic             mem_rd;
    logic             mem_wr;
    logic             reg_wr;
  } id_exe_t;

  typedef struct packed {
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  alu_result;
    logic [XLEN-1:0]  store_data;
    logic [REG_W-1:0] rd;
    logic             mem_rd;
    logic             mem_wr;
    logic             reg_wr;
  } exe_mem_t;

  typedef struct packed {
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  wb_data;
    logic [REG_W-1:0] rd;
    logic             reg_wr;
  } mem_wb_t;

  localparam int unsigned IF_ID_W   = $bits(if_id_t);
  localparam int unsigned ID_EXE_W  = $bits(id_exe_t);
  localparam int unsigned EXE_MEM_W = $bits(exe_mem_t);
  localparam int unsigned MEM_WB_W  = $bits(mem_wb_t);

  // Skid-mode occupancy: TWO means both entries hold a beat.
  function automatic logic ps_full(input pipe_state_t s);
    return s == PS_TWO;
  endfunction

endpackage

// File: rtl/mips_sat_counter.sv
// Saturating up-counter used for per-stage stall / bubble statistics.
module mips_sat_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             inc,
  output logic [CNT_W-1:0] value
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Stops at all-ones instead of wrapping so long runs never alias to small counts.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      value <= '0;
    end else if (inc && (value != CNT_MAX)) begin
      value <= value + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mips_pipe_stage.sv
// Generic inter-stage pipeline register with valid/ready handshake, freeze,
// flush, optional two-entry skid buffer and CPI stall/bubble counters.
module mips_pipe_stage
  import mips_pipe_pkg::*;
#(
  parameter int unsigned PAYLOAD_W = EXE_MEM_W,
  parameter int unsigned SKID      = 1,
  parameter int unsigned CNT_W     = 32
) (
  input  logic                 clk,
  input  logic                 rst_b,
  input  logic                 freeze,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PAYLOAD_W-1:0] in_payload,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PAYLOAD_W-1:0] out_payload,
  output logic [CNT_W-1:0]     stall_cnt,
  output logic [CNT_W-1:0]     bubble_cnt
);

  logic base_ready;
  logic in_xfer;
  logic out_xfer;
  logic stall_inc;
  logic bubble_inc;

  // Flush always accepts (and drops) the beat; freeze blocks acceptance otherwise.
  assign in_ready = rst_b & (flush | (~freeze & base_ready));

  assign in_xfer  = in_valid & in_ready & ~flush;
  assign out_xfer = out_valid & out_ready & ~freeze & ~flush;

  assign stall_inc  = (out_valid & ~out_ready) | freeze;
  assign bubble_inc = ~out_valid & ~freeze;

  generate
    if (SKID == 0) begin : g_single
      logic                 valid_q;
      logic [PAYLOAD_W-1:0] main_q;

      // Ready is combinational from out_ready: a full register frees up on the same cycle.
      assign base_ready = ~valid_q | out_ready;

      always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
          valid_q <= 1'b0;
          main_q  <= '0;
        end else if (flush) begin
          valid_q <= 1'b0;
        end else if (!freeze) begin
          if (in_xfer) begin
            valid_q <= 1'b1;
            main_q  <= in_payload;
          end else if (out_xfer) begin
            valid_q <= 1'b0;
          end
        end
      end

      assign out_valid   = valid_q;
      assign out_payload = main_q;

    end else begin : g_skid
      pipe_state_t          state_q;
      pipe_state_t          state_d;
      logic [PAYLOAD_W-1:0] main_q;
      logic [PAYLOAD_W-1:0] skid_q;
      logic                 load_main_in;
      logic                 load_main_skid;
      logic                 load_skid;

      // Ready depends only on registered occupancy, cutting the out_ready path.
      assign base_ready = ~ps_full(state_q);

      always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
          state_q <= PS_EMPTY;
        end else begin
          state_q <= state_d;
        end
      end

      always_comb begin
        state_d = state_q;
        if (flush) begin
          state_d = PS_EMPTY;
        end else if (!freeze) begin
          case (state_q)
            PS_EMPTY: if (in_xfer) state_d = PS_ONE;
            PS_ONE: begin
              if (in_xfer && !out_xfer) begin
                state_d = PS_TWO;
              end else if (!in_xfer && out_xfer) begin
                state_d = PS_EMPTY;
              end
            end
            PS_TWO:   if (out_xfer) state_d = PS_ONE;
            default:  state_d = PS_EMPTY;
          endcase
        end
      end

      // Transfer qualifiers already exclude flush and freeze, so no extra gating here.
      always_comb begin
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        case (state_q)
          PS_EMPTY: load_main_in = in_xfer;
          PS_ONE: begin
            load_main_in = in_xfer & out_xfer;
            load_skid    = in_xfer & ~out_xfer;
          end
          PS_TWO:   load_main_skid = out_xfer;
          default: begin
            load_main_in   = 1'b0;
            load_main_skid = 1'b0;
            load_skid      = 1'b0;
          end
        endcase
      end

      always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
          main_q <= '0;
          skid_q <= '0;
        end else begin
          if (load_main_in) begin
            main_q <= in_payload;
          end else if (load_main_skid) begin
            main_q <= skid_q;
          end
          if (load_skid) begin
            skid_q <= in_payload;
          end
        end
      end

      assign out_valid   = (state_q != PS_EMPTY);
      assign out_payload = main_q;
    end
  endgenerate

  mips_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_b (rst_b),
    .inc   (stall_inc),
    .value (stall_cnt)
  );

  mips_sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .rst_b (rst_b),
    .inc   (bubble_inc),
    .value (bubble_cnt)
  );

endmodule

// File: tb/tb_mips_pipe_stage.sv
// Directed bench for mips_pipe_stage: SKID=0, SKID=1 and a 4-bit-counter
// instance, driven from vector tables plus hand-written reset/saturation runs.
module tb_mips_pipe_stage;
  import mips_pipe_pkg::*;

  localparam int unsigned PW = EXE_MEM_W;
  localparam int unsigned ND = 3;

  logic clk   = 1'b0;
  logic rst_b = 1'b1;

  logic          in_valid   [ND];
  logic          out_ready  [ND];
  logic          freeze     [ND];
  logic          flush      [ND];
  logic          in_ready   [ND];
  logic          out_valid  [ND];
  logic [PW-1:0] in_payload [ND];
  logic [PW-1:0] out_payload[ND];
  logic [31:0]   stall_cnt  [2];
  logic [31:0]   bubble_cnt [2];
  logic [3:0]    s_stall;
  logic [3:0]    s_bubble;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // Instance 0: single register; 1: skid buffer; 2: skid buffer with 4-bit counters.
  mips_pipe_stage #(.PAYLOAD_W(PW), .SKID(0), .CNT_W(32)) u_d0 (
    .clk(clk), .rst_b(rst_b), .freeze(freeze[0]), .flush(flush[0]),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_payload(in_payload[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_payload(out_payload[0]),
    .stall_cnt(stall_cnt[0]), .bubble_cnt(bubble_cnt[0])
  );

  mips_pipe_stage #(.PAYLOAD_W(PW), .SKID(1), .CNT_W(32)) u_d1 (
    .clk(clk), .rst_b(rst_b), .freeze(freeze[1]), .flush(flush[1]),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_payload(in_payload[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_payload(out_payload[1]),
    .stall_cnt(stall_cnt[1]), .bubble_cnt(bubble_cnt[1])
  );

  mips_pipe_stage #(.PAYLOAD_W(PW), .SKID(1), .CNT_W(4)) u_ds (
    .clk(clk), .rst_b(rst_b), .freeze(freeze[2]), .flush(flush[2]),
    .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_payload(in_payload[2]),
    .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_payload(out_payload[2]),
    .stall_cnt(s_stall), .bubble_cnt(s_bubble)
  );

  typedef struct {
    logic          iv;
    logic          ordy;
    logic          fz;
    logic          fl;
    logic [PW-1:0] pl;
    logic          rdy;
    logic          vld;
    logic [PW-1:0] e_pl;
    int unsigned   e_st;
    int unsigned   e_bu;
  } vec_t;

  vec_t tab1[$];
  vec_t tab0[$];

  function automatic vec_t mk(input bit iv, input bit ordy, input bit fz, input bit fl,
                              input int unsigned pl, input bit rdy, input bit vld,
                              input int unsigned epl, input int unsigned st,
                              input int unsigned bu);
    vec_t v;
    v.iv = iv; v.ordy = ordy; v.fz = fz; v.fl = fl; v.pl = PW'(pl);
    v.rdy = rdy; v.vld = vld; v.e_pl = PW'(epl); v.e_st = st; v.e_bu = bu;
    return v;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset(input string tag);
    rst_b = 1'b0;
    for (int k = 0; k < ND; k++) begin
      in_valid[k] = 1'b0; out_ready[k] = 1'b0; freeze[k] = 1'b0;
      flush[k] = 1'b0; in_payload[k] = '0;
    end
    #1;
    for (int k = 0; k < ND; k++) begin
      chk($sformatf("%s.rst_vld%0d", tag, k), 128'(out_valid[k]), 128'(0));
      chk($sformatf("%s.rst_pl%0d", tag, k), 128'(out_payload[k]), 128'(0));
      chk($sformatf("%s.rst_rdy%0d", tag, k), 128'(in_ready[k]), 128'(0));
    end
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s.rst_stall%0d", tag, k), 128'(stall_cnt[k]), 128'(0));
      chk($sformatf("%s.rst_bubble%0d", tag, k), 128'(bubble_cnt[k]), 128'(0));
    end
    chk({tag, ".rst_sstall"}, 128'(s_stall), 128'(0));
    chk({tag, ".rst_sbubble"}, 128'(s_bubble), 128'(0));
    @(posedge clk); #1;
    rst_b = 1'b1;
    #1;
    for (int k = 0; k < ND; k++)
      chk($sformatf("%s.post_rdy%0d", tag, k), 128'(in_ready[k]), 128'(1));
  endtask

  task automatic apply(input int k, input vec_t v, input string tag);
    in_valid[k] = v.iv; out_ready[k] = v.ordy; freeze[k] = v.fz;
    flush[k] = v.fl; in_payload[k] = v.pl;
    #2;
    chk({tag, ".in_ready"}, 128'(in_ready[k]), 128'(v.rdy));
    @(posedge clk); #1;
    chk({tag, ".out_valid"}, 128'(out_valid[k]), 128'(v.vld));
    if (v.vld) chk({tag, ".out_payload"}, 128'(out_payload[k]), 128'(v.e_pl));
    chk({tag, ".stall_cnt"}, 128'(stall_cnt[k]), 128'(v.e_st));
    chk({tag, ".bubble_cnt"}, 128'(bubble_cnt[k]), 128'(v.e_bu));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    localparam int unsigned A = 'hA1, B = 'hB2, C = 'hC3, X = 'h58, Y = 'h59;
    localparam int unsigned P = 'h71, Q = 'h72, Z = 'h7A;
    logic [PW-1:0] pat_aa;

    // Skid-mode sequence: stream, backpressure, freeze, flush in TWO.
    for (int k = 1; k <= 8; k++) tab1.push_back(mk(1,1,0,0,k, 1,1,k, 0,1));
    tab1.push_back(mk(0,1,0,0,0, 1,0,0, 0,1));
    tab1.push_back(mk(0,1,0,0,0, 1,0,0, 0,2));
    tab1.push_back(mk(1,0,0,0,A, 1,1,A, 0,3));
    tab1.push_back(mk(1,0,0,0,B, 1,1,A, 1,3));
    tab1.push_back(mk(1,0,0,0,C, 0,1,A, 2,3));
    tab1.push_back(mk(1,0,0,0,C, 0,1,A, 3,3));
    tab1.push_back(mk(1,1,0,0,C, 0,1,B, 3,3));
    tab1.push_back(mk(1,1,0,0,C, 1,1,C, 3,3));
    tab1.push_back(mk(0,1,0,0,0, 1,0,0, 3,3));
    tab1.push_back(mk(1,0,0,0,X, 1,1,X, 3,4));
    tab1.push_back(mk(1,1,1,0,Y, 0,1,X, 4,4));
    tab1.push_back(mk(1,1,1,0,Y, 0,1,X, 5,4));
    tab1.push_back(mk(1,1,1,0,Y, 0,1,X, 6,4));
    tab1.push_back(mk(1,1,0,0,Y, 1,1,Y, 6,4));
    tab1.push_back(mk(0,1,0,0,0, 1,0,0, 6,4));
    tab1.push_back(mk(1,0,0,0,P, 1,1,P, 6,5));
    tab1.push_back(mk(1,0,0,0,Q, 1,1,P, 7,5));
    tab1.push_back(mk(1,1,1,1,Z, 1,0,0, 8,5));
    tab1.push_back(mk(0,1,0,0,0, 1,0,0, 8,6));

    // Single-register sequence: same scenarios, combinational in_ready.
    for (int k = 1; k <= 8; k++) tab0.push_back(mk(1,1,0,0,k, 1,1,k, 0,1));
    tab0.push_back(mk(0,1,0,0,0, 1,0,0, 0,1));
    tab0.push_back(mk(0,1,0,0,0, 1,0,0, 0,2));
    tab0.push_back(mk(1,0,0,0,A, 1,1,A, 0,3));
    tab0.push_back(mk(1,0,0,0,B, 0,1,A, 1,3));
    tab0.push_back(mk(1,0,0,0,B, 0,1,A, 2,3));
    tab0.push_back(mk(1,1,0,0,B, 1,1,B, 2,3));
    tab0.push_back(mk(1,1,0,0,C, 1,1,C, 2,3));
    tab0.push_back(mk(0,1,0,0,0, 1,0,0, 2,3));
    tab0.push_back(mk(1,0,0,0,X, 1,1,X, 2,4));
    tab0.push_back(mk(1,1,1,0,Y, 0,1,X, 3,4));
    tab0.push_back(mk(1,1,1,0,Y, 0,1,X, 4,4));
    tab0.push_back(mk(1,1,1,0,Y, 0,1,X, 5,4));
    tab0.push_back(mk(1,1,0,0,Y, 1,1,Y, 5,4));
    tab0.push_back(mk(0,1,0,0,0, 1,0,0, 5,4));
    tab0.push_back(mk(1,0,0,0,P, 1,1,P, 5,5));
    tab0.push_back(mk(1,1,1,1,Z, 1,0,0, 6,5));
    tab0.push_back(mk(0,1,0,0,0, 1,0,0, 6,6));

    #1;
    do_reset("init");

    // Reset asserted mid-traffic clears held state asynchronously.
    pat_aa = {13{8'hAA}};
    in_valid[1] = 1'b1; in_payload[1] = pat_aa; out_ready[1] = 1'b0;
    @(posedge clk); #1;
    chk("mid.vld", 128'(out_valid[1]), 128'(1));
    chk("mid.pl", 128'(out_payload[1]), 128'(pat_aa));
    chk("mid.bubble", 128'(bubble_cnt[1]), 128'(1));
    in_valid[1] = 1'b0;
    @(posedge clk); #1;
    chk("mid.stall", 128'(stall_cnt[1]), 128'(1));
    #2;
    do_reset("mid");

    foreach (tab1[i]) apply(1, tab1[i], $sformatf("s1[%0d]", i));

    do_reset("s0");
    foreach (tab0[i]) apply(0, tab0[i], $sformatf("s0[%0d]", i));

    // 4-bit stall counter must stop at 15 under a long stall.
    do_reset("sat");
    in_valid[2] = 1'b1; in_payload[2] = PW'(32'h5A7); out_ready[2] = 1'b0;
    @(posedge clk); #1;
    chk("sat.vld", 128'(out_valid[2]), 128'(1));
    chk("sat.bubble0", 128'(s_bubble), 128'(1));
    in_valid[2] = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      chk($sformatf("sat.stall[%0d]", i), 128'(s_stall), 128'((i < 15) ? i : 15));
    end
    chk("sat.bubble", 128'(s_bubble), 128'(1));
    chk("sat.pl", 128'(out_payload[2]), 128'(32'h5A7));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
